complex_up_counter_4bit: RTL and testbench

Programmable 4-bit BCD-range up-counter. It counts 0 up to a mode-selected terminal value (9, 5 or 1), then wraps to 0. It is the counting-up counterpart of the team's mode-selectable down-counter and shares the same Mode encoding. Tc/Carry outputs allow synchronous cascading of stages, e.g. a seconds/minutes chain where the Carry of one stage drives the Enable of the next.

---
 rtl/complex_up_counter_4bit_pkg.sv | 21 ++
 rtl/complex_up_counter_4bit_if.sv | 25 ++
 rtl/complex_up_counter_4bit_mode_decode.sv | 16 +
 rtl/complex_up_counter_4bit.sv | 77 +++++++
 tb/tb_complex_up_counter_4bit.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/complex_up_counter_4bit_pkg.sv
// Shared definitions for the mode-selectable BCD-range counters (up and down).
package complex_up_counter_4bit_pkg;

    // Terminal-value codes accepted on Mode.
    localparam logic [3:0] MODE_9 = 4'd9;
    localparam logic [3:0] MODE_5 = 4'd5;
    localparam logic [3:0] MODE_1 = 4'd1;

    // Counter control states.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StHold = 2'd2
    } state_e;

    // True for the mode codes that may be loaded into Limit.
    function automatic logic is_valid_mode(input logic [3:0] mode);
        return (mode == MODE_9) || (mode == MODE_5) || (mode == MODE_1);
    endfunction

endpackage

// File: rtl/complex_up_counter_4bit_if.sv
// Control and status bundle of one counter stage.
interface complex_up_counter_4bit_if #(
    parameter int unsigned WIDTH = 4
);
    logic             Enable;
    logic             Clear;
    logic [WIDTH-1:0] Mode;
    logic [WIDTH-1:0] Count;
    logic [WIDTH-1:0] Limit;
    logic             Busy;
    logic             Tc;
    logic             Carry;

    // Controller side: drives Enable/Clear/Mode, observes status.
    modport master (
        output Enable, Clear, Mode,
        input  Count, Limit, Busy, Tc, Carry
    );

    // Counter side.
    modport slave (
        input  Enable, Clear, Mode,
        output Count, Limit, Busy, Tc, Carry
    );
endinterface

// File: rtl/complex_up_counter_4bit_mode_decode.sv
// Decodes the requested Mode into a candidate terminal value and a validity flag.
module up_counter_mode_decode
    import complex_up_counter_4bit_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] mode_i,
    output logic [WIDTH-1:0] limit_o,
    output logic             valid_o
);

    // Only codes that fit in 4 bits can match one of the mode constants.
    assign limit_o = mode_i;
    assign valid_o = (32'(mode_i) < 32'd16) && is_valid_mode(4'(mode_i));

endmodule

// File: rtl/complex_up_counter_4bit.sv
// Programmable up-counter: counts 0..Limit then wraps; Limit re-sampled on wrap/Clear.
module complex_up_counter_4bit
    import complex_up_counter_4bit_pkg::*;
#(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned RESET_LIMIT = 9
) (
    input  logic                           Clk,
    input  logic                           Reset,
    complex_up_counter_4bit_if.slave       bus
);

    localparam logic [WIDTH-1:0] ResetLimit = WIDTH'(RESET_LIMIT);

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    state_e           state_q, state_d;

    logic [WIDTH-1:0] mode_limit;
    logic             mode_valid;
    logic             at_limit;

    up_counter_mode_decode #(
        .WIDTH (WIDTH)
    ) u_mode_decode (
        .mode_i  (bus.Mode),
        .limit_o (mode_limit),
        .valid_o (mode_valid)
    );

    assign at_limit = (count_q == limit_q);

    // Next-state: Clear beats Enable; Limit only reloads on Clear or wrap.
    always_comb begin
        count_d = count_q;
        limit_d = limit_q;
        state_d = state_q;
        if (bus.Clear) begin
            count_d = '0;
            state_d = StIdle;
            if (mode_valid) limit_d = mode_limit;
        end else if (bus.Enable) begin
            state_d = StRun;
            if (at_limit) begin
                count_d = '0;
                if (mode_valid) limit_d = mode_limit;
            end else begin
                count_d = count_q + WIDTH'(1);
            end
        end else if (state_q == StRun) begin
            state_d = StHold;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            count_q <= '0;
            limit_q <= ResetLimit;
            state_q <= StIdle;
        end else begin
            count_q <= count_d;
            limit_q <= limit_d;
            state_q <= state_d;
        end
    end

    // Status outputs; Carry flags the cycle before a wrap edge for cascading.
    always_comb begin
        bus.Count = count_q;
        bus.Limit = limit_q;
        bus.Busy  = (state_q != StIdle);
        bus.Tc    = at_limit;
        bus.Carry = at_limit & bus.Enable & ~bus.Clear & ~Reset;
    end

endmodule

// File: tb/tb_complex_up_counter_4bit.sv
// Self-checking bench: directed vector table, corner sequences, cascade, random vs model.
module tb_complex_up_counter_4bit;

    logic clk;
    logic rst;

    complex_up_counter_4bit_if #(.WIDTH(4)) a_if ();
    complex_up_counter_4bit_if #(.WIDTH(4)) b_if ();

    complex_up_counter_4bit #(
        .WIDTH       (4),
        .RESET_LIMIT (9)
    ) u_a (
        .Clk   (clk),
        .Reset (rst),
        .bus   (a_if.slave)
    );

    complex_up_counter_4bit #(
        .WIDTH       (4),
        .RESET_LIMIT (9)
    ) u_b (
        .Clk   (clk),
        .Reset (rst),
        .bus   (b_if.slave)
    );

    // Stage B counts on stage A's carry.
    assign b_if.Enable = a_if.Carry;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit       r;
        bit       e;
        bit       c;
        int       mode;
        int       exp_count;
        int       exp_limit;
        bit       exp_busy;
        bit       exp_carry;
    } vec_t;

    vec_t vecs[$];

    // Reference model state.
    int m_cnt;
    int m_lim;
    bit m_busy;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input bit r, input bit e, input bit c, input int mode,
                       input int ec, input int el, input bit eb, input bit ecar);
        vec_t v;
        v.r = r; v.e = e; v.c = c; v.mode = mode;
        v.exp_count = ec; v.exp_limit = el; v.exp_busy = eb; v.exp_carry = ecar;
        vecs.push_back(v);
    endtask

    task automatic drive(input bit r, input bit e, input bit c, input int mode);
        rst          = r;
        a_if.Enable  = e;
        a_if.Clear   = c;
        a_if.Mode    = 4'(mode);
    endtask

    task automatic edge_wait();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input bit r, input bit e, input bit c, input int mode);
        drive(r, e, c, mode);
        @(negedge clk);
        edge_wait();
    endtask

    // Behavioural rules: reset > clear > enable > hold.
    task automatic m_step(input bit r, input bit e, input bit c, input int mode);
        bit valid;
        valid = (mode == 9) || (mode == 5) || (mode == 1);
        if (r) begin
            m_cnt = 0; m_lim = 9; m_busy = 0;
        end else if (c) begin
            m_cnt = 0; m_busy = 0;
            if (valid) m_lim = mode;
        end else if (e) begin
            m_busy = 1;
            if (m_cnt == m_lim) begin
                m_cnt = 0;
                if (valid) m_lim = mode;
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
    endtask

    initial begin
        int b_pulses;
        rst = 1'b1;
        a_if.Enable = 1'b0;
        a_if.Clear  = 1'b0;
        a_if.Mode   = 4'd9;
        b_if.Clear  = 1'b0;
        b_if.Mode   = 4'd9;
        edge_wait();

        // Plan: reset then Mode=9 counting for 12 edges.
        add(1, 0, 0, 9, 0, 9, 0, 0);
        for (int i = 1; i <= 12; i++) add(0, 1, 0, 9, i % 10, 9, 1, i == 10);
        // Clear loads Mode=5; Mode=1 requested mid-count takes effect at wrap.
        add(0, 0, 1, 5, 0, 5, 0, 0);
        add(0, 1, 0, 5, 1, 5, 1, 0);
        add(0, 1, 0, 5, 2, 5, 1, 0);
        add(0, 1, 0, 5, 3, 5, 1, 0);
        add(0, 1, 0, 1, 4, 5, 1, 0);
        add(0, 1, 0, 1, 5, 5, 1, 0);
        add(0, 1, 0, 1, 0, 1, 1, 1);
        add(0, 1, 0, 1, 1, 1, 1, 0);
        add(0, 1, 0, 1, 0, 1, 1, 1);
        add(0, 1, 0, 1, 1, 1, 1, 0);
        // Reset while Tc high: Carry masked, Limit back to 9; invalid Mode ignored.
        add(1, 0, 0, 1, 0, 9, 0, 0);
        add(0, 0, 1, 7, 0, 9, 0, 0);
        for (int i = 1; i <= 10; i++) add(0, 1, 0, 7, i % 10, 9, 1, i == 10);
        add(0, 1, 0, 7, 1, 9, 1, 0);
        // Clear with Enable: no count, valid Mode loaded.
        add(0, 1, 1, 5, 0, 5, 0, 0);

        foreach (vecs[k]) begin
            drive(vecs[k].r, vecs[k].e, vecs[k].c, vecs[k].mode);
            @(negedge clk);
            chk($sformatf("vec%0d_carry", k), int'(a_if.Carry), int'(vecs[k].exp_carry));
            edge_wait();
            chk($sformatf("vec%0d_count", k), int'(a_if.Count), vecs[k].exp_count);
            chk($sformatf("vec%0d_limit", k), int'(a_if.Limit), vecs[k].exp_limit);
            chk($sformatf("vec%0d_busy", k), int'(a_if.Busy), int'(vecs[k].exp_busy));
            chk($sformatf("vec%0d_tc", k), int'(a_if.Tc),
                int'(vecs[k].exp_count == vecs[k].exp_limit));
        end

        // Hold: Enable low at Count=4 for 3 edges.
        cyc(1, 0, 0, 9);
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 9);
        chk("hold_start_count", int'(a_if.Count), 4);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 9);
            @(negedge clk);
            chk("hold_carry", int'(a_if.Carry), 0);
            edge_wait();
            chk("hold_count", int'(a_if.Count), 4);
            chk("hold_busy", int'(a_if.Busy), 1);
        end
        cyc(0, 1, 0, 9);
        chk("resume_count", int'(a_if.Count), 5);
        cyc(0, 1, 0, 9);
        chk("pre_clear_count", int'(a_if.Count), 6);

        // Clear and Enable together at Count=6.
        drive(0, 1, 1, 9);
        @(negedge clk);
        chk("clr_en_carry", int'(a_if.Carry), 0);
        edge_wait();
        chk("clr_en_count", int'(a_if.Count), 0);
        chk("clr_en_busy", int'(a_if.Busy), 0);

        // Reset at Count=3 with Mode=5.
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 5);
        chk("pre_reset_count", int'(a_if.Count), 3);
        cyc(1, 0, 0, 5);
        chk("reset_mid_count", int'(a_if.Count), 0);
        chk("reset_mid_limit", int'(a_if.Limit), 9);
        chk("reset_mid_busy", int'(a_if.Busy), 0);

        // Carry masked by Clear and by Reset while Tc is high.
        for (int i = 0; i < 9; i++) cyc(0, 1, 0, 9);
        drive(0, 1, 1, 9);
        @(negedge clk);
        chk("tc_before_clear", int'(a_if.Tc), 1);
        chk("carry_masked_clear", int'(a_if.Carry), 0);
        edge_wait();
        for (int i = 0; i < 9; i++) cyc(0, 1, 0, 9);
        drive(1, 1, 0, 9);
        @(negedge clk);
        chk("carry_masked_reset", int'(a_if.Carry), 0);
        drive(0, 1, 0, 9);
        #1;
        chk("carry_at_limit", int'(a_if.Carry), 1);
        edge_wait();
        chk("wrap_count", int'(a_if.Count), 0);

        // Cascade: B steps once per 10 enabled A cycles and wraps after 100.
        cyc(1, 0, 0, 9);
        b_pulses = 0;
        for (int i = 1; i <= 100; i++) begin
            drive(0, 1, 0, 9);
            @(negedge clk);
            if (b_if.Carry) b_pulses++;
            edge_wait();
            chk($sformatf("chain_b_count_%0d", i), int'(b_if.Count), (i / 10) % 10);
            if (i % 25 == 0) chk($sformatf("chain_a_count_%0d", i), int'(a_if.Count), i % 10);
        end
        chk("chain_b_carry_pulses", b_pulses, 1);

        // Random stimulus against the reference model.
        cyc(1, 0, 0, 9);
        m_step(1, 0, 0, 9);
        for (int i = 0; i < 400; i++) begin
            bit r, e, c;
            int mode;
            r = ($urandom_range(0, 31) == 0);
            c = ($urandom_range(0, 9) == 0);
            e = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0: mode = 9;
                1: mode = 5;
                2: mode = 1;
                default: mode = $urandom_range(0, 15);
            endcase
            drive(r, e, c, mode);
            @(negedge clk);
            chk($sformatf("rnd%0d_count", i), int'(a_if.Count), m_cnt);
            chk($sformatf("rnd%0d_limit", i), int'(a_if.Limit), m_lim);
            chk($sformatf("rnd%0d_busy", i), int'(a_if.Busy), int'(m_busy));
            chk($sformatf("rnd%0d_tc", i), int'(a_if.Tc), int'(m_cnt == m_lim));
            chk($sformatf("rnd%0d_carry", i), int'(a_if.Carry),
                int'((m_cnt == m_lim) && e && !c && !r));
            edge_wait();
            m_step(r, e, c, mode);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
